// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan controller:
//   - state_t    : scan FSM states
//   - SEG_OFF    : all-segments-off pattern (active-low, dp included)
//   - SEG_DARK   : segments a..g off (dp excluded)
//   - SEG_TABLE  : hex -> segment bits [6:0] (g..a), active-low
//   - hex_to_seg : table lookup returning an 8-bit pattern with dp off
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Index = hex value; bit 6 = g ... bit 0 = a; 0 = segment lit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    return {1'b1, SEG_TABLE[hex]};
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// SegmentDecoder
//   Combinational hex-to-7-segment decoder, active-low outputs.
//   Ports:
//     hex  in  4  hex nibble to display
//     seg  out 8  [7] = dp (always off here), [6:0] = g..a
// -----------------------------------------------------------------------------
module SegmentDecoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment
//   display. One shared decoder is fed by the nibble of the digit currently
//   being scanned. A blanking gap between digits suppresses ghosting, and the
//   display data is double-buffered so new values appear only at a frame
//   boundary.
//   Ports:
//     clk        in   1            system clock, rising edge
//     rst_n      in   1            asynchronous active-low reset
//     enable     in   1            1 = scan, 0 = display dark
//     load       in   1            strobe: capture data_in/dp_in/blank_in
//     data_in    in   4*N_DIGITS   digit i = data_in[4i+3:4i], digit 0 rightmost
//     dp_in      in   N_DIGITS     decimal point per digit, 1 = lit
//     blank_in   in   N_DIGITS     1 = digit dark (anode still scanned)
//     AN         out  N_DIGITS     anode selects, active-low
//     SEGMENT    out  8            [7] = dp, [6:0] = g..a, active-low
//     frame_done out  1            1-cycle pulse when the digit index wraps
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic [N_DIGITS-1:0]     AN,
  output logic [7:0]              SEGMENT,
  output logic                    frame_done
);

  localparam int unsigned CNT_SPAN_T = (TICK_CYCLES  > 2) ? TICK_CYCLES  : 2;
  localparam int unsigned CNT_SPAN_B = (BLANK_CYCLES > 2) ? BLANK_CYCLES : 2;
  localparam int unsigned CNT_SPAN   = (CNT_SPAN_T > CNT_SPAN_B) ? CNT_SPAN_T : CNT_SPAN_B;
  localparam int unsigned CW         = $clog2(CNT_SPAN);
  localparam int unsigned IW         = $clog2(N_DIGITS);

  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYCLES - 1);
  // Only meaningful when BLANK_CYCLES > 0; the BLANK state is unreachable otherwise.
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(N_DIGITS - 1);

  state_t               state;
  logic [IW-1:0]        index;
  logic [CW-1:0]        count;

  logic [4*N_DIGITS-1:0] disp_data;
  logic [N_DIGITS-1:0]   disp_dp;
  logic [N_DIGITS-1:0]   disp_blank;
  logic [4*N_DIGITS-1:0] pend_data;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   pend_blank;
  logic                  pend_valid;

  logic                  advance;
  logic                  wrap;
  logic                  commit;
  logic [IW-1:0]         next_index;

  logic [3:0]            nibble;
  logic                  dp_bit;
  logic                  blank_bit;
  logic [N_DIGITS-1:0]   digit_sel;
  logic                  lit;
  logic [6:0]            dec_seg;
  logic                  dec_dp_unused;

  // ---------------------------------------------------------------------------
  // Slot sequencing: advance fires on the last cycle of a digit's slot
  // (end of BLANK, or end of ACTIVE when there is no gap).
  // ---------------------------------------------------------------------------
  always_comb begin
    advance = 1'b0;
    commit  = 1'b0;
    wrap    = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE:    commit  = pend_valid;
        ACTIVE:  advance = (count == TICK_LAST) && (BLANK_CYCLES == 0);
        BLANK:   advance = (count == BLANK_LAST);
        default: advance = 1'b0;
      endcase
    end
    wrap = advance && (index == INDEX_LAST);
    if (wrap) begin
      commit = pend_valid;
    end
  end

  assign next_index = (index == INDEX_LAST) ? '0 : index + IW'(1);

  // ---------------------------------------------------------------------------
  // Scan FSM, digit index and slot counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
      count <= '0;
    end else if (!enable) begin
      state <= IDLE;
      index <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= ACTIVE;
          index <= '0;
          count <= '0;
        end
        ACTIVE: begin
          if (count == TICK_LAST) begin
            count <= '0;
            if (BLANK_CYCLES == 0) begin
              index <= next_index;
            end else begin
              state <= BLANK;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        BLANK: begin
          if (count == BLANK_LAST) begin
            count <= '0;
            state <= ACTIVE;
            index <= next_index;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
          count <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer. A load coinciding with a commit lands in pending after the
  // old pending value has moved to the display, so pend_valid stays set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (commit) begin
        disp_data  <= pend_data;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit mux feeding the shared decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble    = '0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (index == IW'(i)) begin
        nibble    = disp_data[4*i +: 4];
        dp_bit    = disp_dp[i];
        blank_bit = disp_blank[i];
      end
    end
  end

  SegmentDecoder u_decoder (
    .hex (nibble),
    .seg ({dec_dp_unused, dec_seg})
  );

  assign digit_sel = N_DIGITS'(1) << index;

  // Outputs trail the state by one cycle; enable is folded in so that the
  // display goes dark on the same edge the FSM drops to IDLE.
  assign lit = enable && (state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AN         <= '1;
      SEGMENT    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (lit) begin
        AN      <= ~digit_sel;
        SEGMENT <= {~dp_bit, blank_bit ? SEG_DARK : dec_seg};
      end else begin
        AN      <= '1;
        SEGMENT <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Drives two controllers (with and without a blanking gap) from the same
//   stimulus and compares every cycle against a frame/slot arithmetic model.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int unsigned N_DIG = 4;
  localparam int unsigned T_CYC = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] data_in  = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  blank_in = '0;

  logic [3:0]  an0, an1;
  logic [7:0]  seg0, seg1;
  logic        fd0, fd1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.N_DIGITS(4), .TICK_CYCLES(4), .BLANK_CYCLES(1)) dut_gap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .AN(an0), .SEGMENT(seg0), .frame_done(fd0)
  );

  seg_scan_ctrl #(.N_DIGITS(4), .TICK_CYCLES(4), .BLANK_CYCLES(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .AN(an1), .SEGMENT(seg1), .frame_done(fd1)
  );

  // Reference decode table (bits [6:0], active-low)
  logic [6:0] seg7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model state, one entry per instance
  int unsigned blank_len [2] = '{1, 0};
  bit          run   [2];
  int unsigned t     [2];
  logic [15:0] m_disp [2];
  logic [3:0]  m_dp   [2];
  logic [3:0]  m_blk  [2];
  logic [15:0] m_pdat [2];
  logic [3:0]  m_pdp  [2];
  logic [3:0]  m_pblk [2];
  bit          m_pv   [2];
  logic [3:0]  e_an  [2];
  logic [7:0]  e_seg [2];
  logic        e_fd  [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 1'b0;  t[i] = 0;
      m_disp[i] = '0; m_dp[i] = '0;  m_blk[i] = '0;
      m_pdat[i] = '0; m_pdp[i] = '0; m_pblk[i] = '0; m_pv[i] = 1'b0;
      e_an[i] = 4'hF; e_seg[i] = 8'hFF; e_fd[i] = 1'b0;
    end
  endtask

  // One clock edge of the model: outputs are derived from the position t
  // inside the frame (slot = lit time + gap), then buffers are updated.
  task automatic model_edge(input int i);
    int unsigned slot, frame, p, d;
    logic [3:0]  nib;
    bit          commit;
    slot   = T_CYC + blank_len[i];
    frame  = N_DIG * slot;
    commit = 1'b0;
    e_an[i] = 4'hF; e_seg[i] = 8'hFF; e_fd[i] = 1'b0;
    if (!enable) begin
      run[i] = 1'b0;
    end else if (!run[i]) begin
      run[i] = 1'b1;
      t[i]   = 0;
      commit = m_pv[i];
    end else begin
      p = t[i] % frame;
      d = p / slot;
      if ((p % slot) < T_CYC) begin
        nib      = 4'(m_disp[i] >> (4 * d));
        e_an[i]  = 4'hF ^ (4'b0001 << d);
        e_seg[i] = {~m_dp[i][d], m_blk[i][d] ? 7'h7F : seg7[nib]};
      end
      if (p == frame - 1) begin
        e_fd[i] = 1'b1;
        commit  = m_pv[i];
      end
      t[i] = t[i] + 1;
    end
    if (commit) begin
      m_disp[i] = m_pdat[i]; m_dp[i] = m_pdp[i]; m_blk[i] = m_pblk[i];
      m_pv[i]   = 1'b0;
    end
    if (load) begin
      m_pdat[i] = data_in; m_pdp[i] = dp_in; m_pblk[i] = blank_in;
      m_pv[i]   = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("an_gap",    {4'h0, an0},  {4'h0, e_an[0]});
    check("seg_gap",   seg0,         e_seg[0]);
    check("fd_gap",    {7'h0, fd0},  {7'h0, e_fd[0]});
    check("an_nogap",  {4'h0, an1},  {4'h0, e_an[1]});
    check("seg_nogap", seg1,         e_seg[1]);
    check("fd_nogap",  {7'h0, fd1},  {7'h0, e_fd[1]});
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an0"},  {4'h0, an0}, 8'h0F);
    check({tag, "_seg0"}, seg0,        8'hFF);
    check({tag, "_fd0"},  {7'h0, fd0}, 8'h00);
    check({tag, "_an1"},  {4'h0, an1}, 8'h0F);
    check({tag, "_seg1"}, seg1,        8'hFF);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  cnt0, cnt1;
    bit  found;
    logic [3:0] first_an;

    model_reset();
    #1 rst_n = 1'b0;
    #20;
    check_dark("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. scan with no load: zeros everywhere, frame_done counted
    enable = 1'b1;
    step();
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (fd0) cnt0++;
      if (fd1) cnt1++;
    end
    check("fd_count_gap",   8'(cnt0), 8'd3);
    check("fd_count_nogap", 8'(cnt1), 8'd3);

    // 2. mid-frame load becomes visible only after the next wrap
    run_steps(7);
    do_load(16'h12AF, 4'b0100, 4'b0000);
    run_steps(45);

    // 3. two loads in one frame: last one wins
    run_steps(3);
    do_load(16'h1111, 4'b0000, 4'b0000);
    run_steps(4);
    do_load(16'h2222, 4'b0000, 4'b0000);
    run_steps(45);

    // 4. blanked digit 3
    do_load(16'h2222, 4'b0000, 4'b1000);
    run_steps(45);

    // 5. drop enable while digit 2 is lit, then restart at digit 0
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (e_an[0] == 4'hB) found = 1'b1;
      else step();
    end
    check("find_digit2", {7'h0, found}, 8'h01);
    enable = 1'b0;
    step();
    check("disable_an",  {4'h0, an0}, 8'h0F);
    check("disable_seg", seg0,        8'hFF);
    run_steps(3);
    enable = 1'b1;
    first_an = 4'hF;
    for (int k = 0; k < 10 && first_an == 4'hF; k++) begin
      step();
      first_an = an0;
    end
    check("reenable_first_an", {4'h0, first_an}, 8'h0E);
    run_steps(25);

    // 6. async reset mid-scan with pending data
    run_steps(2);
    do_load(16'h5555, 4'b1111, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_steps(3);
    check("after_reset_seg", seg0, 8'hC0);
    run_steps(40);

    // 7. randomized loads and enable drops
    for (int k = 0; k < 400; k++) begin
      if (enable && $urandom_range(0, 39) == 0)       enable = 1'b0;
      else if (!enable && $urandom_range(0, 2) == 0)  enable = 1'b1;
      load     = ($urandom_range(0, 5) == 0);
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
